// File: rtl/baud_pkg.sv
// Shared widths and derived constants for the fractional baud generator.
package baud_pkg;

    localparam int NB_INT_DEF     = 16;
    localparam int NB_FRAC_DEF    = 4;
    localparam int OVERSAMPLE_DEF = 16;

    function automatic int ovs_width(input int ovs);
        return (ovs <= 2) ? 1 : $clog2(ovs);
    endfunction

    function automatic int mid_idx(input int ovs);
        return ovs / 2 - 1;
    endfunction

    localparam int NB_OVS  = ovs_width(OVERSAMPLE_DEF);
    localparam int MID_IDX = mid_idx(OVERSAMPLE_DEF);

endpackage

// File: rtl/baud_frac_div.sv
// Fractional divider: period counter, fraction accumulator and
// shadow/active divisor pair; emits the raw oversample tick.
module baud_frac_div
    import baud_pkg::*;
#(
    parameter int NB_INT       = NB_INT_DEF,
    parameter int NB_FRAC      = NB_FRAC_DEF,
    parameter int DEFAULT_INT  = 326,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_resync,
    input  logic               i_div_wr,
    input  logic [NB_INT-1:0]  i_div_int,
    input  logic [NB_FRAC-1:0] i_div_frac,
    output logic               o_tick,
    output logic               o_div_pending
);

    localparam logic [NB_INT:0] CNT_ONE = (NB_INT+1)'(1);

    logic [NB_INT:0]    cnt;
    logic [NB_INT:0]    eff_int;
    logic [NB_INT:0]    limit;
    logic [NB_FRAC-1:0] frac_acc;
    logic [NB_FRAC:0]   frac_sum;
    logic               carry;
    logic [NB_INT-1:0]  act_int;
    logic [NB_FRAC-1:0] act_frac;
    logic [NB_INT-1:0]  shd_int;
    logic [NB_FRAC-1:0] shd_frac;
    logic               pending;
    logic               restart;
    logic               apply;
    logic               tick;

    always_comb begin
        eff_int  = (act_int == '0) ? CNT_ONE : {1'b0, act_int};
        limit    = eff_int + {{NB_INT{1'b0}}, carry};
        frac_sum = {1'b0, frac_acc} + {1'b0, act_frac};
        restart  = i_resync | ~i_en;
        tick     = i_en & ~i_reset & ~i_resync & (cnt == limit - CNT_ONE);
        apply    = pending & (tick | restart);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt      <= '0;
            frac_acc <= '0;
            carry    <= 1'b0;
            act_int  <= NB_INT'(DEFAULT_INT);
            act_frac <= NB_FRAC'(DEFAULT_FRAC);
            shd_int  <= '0;
            shd_frac <= '0;
            pending  <= 1'b0;
        end else begin
            if (restart) begin
                cnt      <= '0;
                frac_acc <= '0;
                carry    <= 1'b0;
            end else if (tick) begin
                cnt      <= '0;
                frac_acc <= frac_sum[NB_FRAC-1:0];
                carry    <= frac_sum[NB_FRAC];
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if (apply) begin
                act_int  <= shd_int;
                act_frac <= shd_frac;
            end

            // A write in the same cycle as an apply keeps the new value pending.
            if (i_div_wr) begin
                shd_int  <= i_div_int;
                shd_frac <= i_div_frac;
                pending  <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign o_tick        = tick;
    assign o_div_pending = pending;

endmodule

// File: rtl/baud_rate_frac.sv
// Fractional baud generator top: oversample tick plus bit and mid-bit
// decodes derived from the oversample phase counter.
module baud_rate_frac
    import baud_pkg::*;
#(
    parameter int NB_INT       = NB_INT_DEF,
    parameter int NB_FRAC      = NB_FRAC_DEF,
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int DEFAULT_INT  = 326,
    parameter int DEFAULT_FRAC = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_resync,
    input  logic               i_div_wr,
    input  logic [NB_INT-1:0]  i_div_int,
    input  logic [NB_FRAC-1:0] i_div_frac,
    output logic               o_tick,
    output logic               o_bit_tick,
    output logic               o_mid_tick,
    output logic               o_div_pending
);

    localparam int               OVS_W    = ovs_width(OVERSAMPLE);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVERSAMPLE - 1);
    localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(mid_idx(OVERSAMPLE));

    logic             tick;
    logic [OVS_W-1:0] ovs_cnt;

    baud_frac_div #(
        .NB_INT       (NB_INT),
        .NB_FRAC      (NB_FRAC),
        .DEFAULT_INT  (DEFAULT_INT),
        .DEFAULT_FRAC (DEFAULT_FRAC)
    ) u_div (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_resync      (i_resync),
        .i_div_wr      (i_div_wr),
        .i_div_int     (i_div_int),
        .i_div_frac    (i_div_frac),
        .o_tick        (tick),
        .o_div_pending (o_div_pending)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_resync || !i_en) begin
            ovs_cnt <= '0;
        end else if (tick) begin
            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
        end
    end

    assign o_tick     = tick;
    assign o_bit_tick = tick & (ovs_cnt == OVS_LAST);
    assign o_mid_tick = tick & (ovs_cnt == OVS_MID);

endmodule

// File: doc/baud_rate_frac.md
Name: baud_rate_frac

Overview:
Runtime-programmable fractional baud generator: the next generation of the fixed-divisor tick generator, feeding both UART TX and RX.
- Produces an oversample tick (o_tick), a bit tick every OVERSAMPLE ticks (o_bit_tick) and a mid-bit tick for RX sampling (o_mid_tick).
- Divisor = integer part plus NB_FRAC-bit fraction, updated glitch-free at period boundaries.
- i_resync realigns phase to an RX start-bit edge.

Parameters:
NB_INT, 16, width of integer divisor part
NB_FRAC, 4, width of fractional divisor part (fraction = div_frac / 2^NB_FRAC)
OVERSAMPLE, 16, oversample ticks per bit (>=2, even)
DEFAULT_INT, 326, integer divisor loaded at reset
DEFAULT_FRAC, 0, fractional divisor loaded at reset

Ports:
i_clk  input  1  clock, all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_en  input  1  generator enable
i_resync  input  1  one-cycle pulse: restart phase at zero
i_div_wr  input  1  one-cycle pulse: capture new divisor
i_div_int  input  NB_INT  new integer divisor
i_div_frac  input  NB_FRAC  new fractional divisor
o_tick  output  1  oversample tick, one cycle wide
o_bit_tick  output  1  bit-period tick, one cycle wide
o_mid_tick  output  1  mid-bit tick, one cycle wide
o_div_pending  output  1  captured divisor not yet applied

Behaviour:
- Single clock domain i_clk; reset i_reset is synchronous and active-high.
- Reset:
  - cnt=0, frac_acc=0, carry=0, ovs_cnt=0, o_div_pending=0.
  - Active divisor = DEFAULT_INT/DEFAULT_FRAC.
  - All tick outputs 0 during any cycle with i_reset=1.
- Effective integer divisor: eff_int = max(active_int, 1). A value of 0 is treated as 1.
- Period limit: limit = eff_int + carry (width NB_INT+1, no overflow).
- o_tick is combinational: i_en & ~i_reset & ~i_resync & (cnt == limit-1).
- cnt increments each enabled cycle. On o_tick:
  - cnt<=0.
  - {ovf, frac_acc} <= frac_acc + active_frac, with NB_FRAC+1-bit sum; carry<=ovf.
  - ovs_cnt <= (ovs_cnt==OVERSAMPLE-1) ? 0 : ovs_cnt+1.
- The first period after reset/resync/enable has limit = eff_int. Long-run average period = int + frac/2^NB_FRAC cycles.
- o_bit_tick = o_tick & (ovs_cnt == OVERSAMPLE-1).
- o_mid_tick = o_tick & (ovs_cnt == OVERSAMPLE/2-1).
- i_en=0: cnt, frac_acc, carry and ovs_cnt are held at 0; no ticks. The first o_tick comes eff_int cycles after i_en rises.
- Divisor write (i_div_wr=1):
  - i_div_int/i_div_frac are captured into a shadow register and o_div_pending<=1 next cycle.
  - The shadow is applied at the next o_tick cycle (takes effect for the following period), or on the next cycle if i_en=0 or i_resync=1. o_div_pending then clears.
  - A write while pending overwrites the shadow; last write wins.
  - A write coinciding with o_tick: the old shadow (if any) is applied; the new value is pending until the next tick.
- i_resync (priority over tick, below reset):
  - cnt, frac_acc, carry and ovs_cnt <= 0; no tick that cycle; pending divisor applied.
  - Next o_tick comes eff_int cycles after the resync cycle.
- Precedence: i_reset > i_resync > i_en=0 > tick.

Decomposition:
- Package baud_pkg: default widths, OVERSAMPLE default, and the derived constants NB_OVS = clog2(OVERSAMPLE) and MID_IDX = OVERSAMPLE/2-1.
- Sub-module baud_frac_div: cnt, frac_acc, carry, shadow/active divisor; produces the raw tick.
- Top: adds the ovs_cnt and the bit/mid decode.

Test Plan:
1. DEFAULT_INT=4, DEFAULT_FRAC=0, en=1 after reset -> o_tick on cycles 4,8,12 after release; o_bit_tick on every 16th tick (cycle 64); o_mid_tick at tick 8 (cycle 32).
2. int=4, frac=8 (NB_FRAC=4) -> tick intervals 4,4,5,4,5,4,5; 32 ticks span exactly 4+31*4.5 ≈ 143/144 cycles; check frac_acc sequence 8,0,8,0.
3. Write int=6 mid-period (cnt=2, int=4) -> o_div_pending=1 until the current 4-cycle period ends; the next interval is 6; pending clears on the tick cycle.
4. i_resync at cnt=3 of int=5 with ovs_cnt=9 -> no tick that cycle; next tick 5 cycles later; ovs_cnt restarts so o_mid_tick arrives at the 8th tick after resync.
5. i_div_int=0 -> tick every cycle; i_en low for 10 cycles -> no ticks, counters 0; re-enable with int=3 -> first tick 3 cycles later.
6. Assert i_reset mid-period with pending write -> all outputs 0, active divisor back to DEFAULT, pending cleared, restart matches scenario 1.
